// File: rtl/game_pkg.sv
// game_pkg: shared direction/state types and helpers for the move sequencer.
// Contents: dir_e (N=0,E=1,S=2,W=3), state_e (sequencer FSM), opposite().
package game_pkg;
   localparam int DIR_W_BITS = 2;
   typedef enum logic [1:0] {DIR_N, DIR_E, DIR_S, DIR_W} dir_e;
   typedef enum logic [1:0] {ST_IDLE, ST_ARB, ST_ISSUE} state_e;
   function automatic logic [DIR_W_BITS-1:0] opposite(input logic [DIR_W_BITS-1:0] d);
      return d ^ 2'b10;
   endfunction
endpackage

// File: rtl/game_cmd_fifo.sv
// game_cmd_fifo: synchronous FIFO with the head visible combinationally.
// Ports: clk, rst_n (sync, active-low), push/din write, pop read,
//        dout head entry, full/empty status. Push on full and pop on empty are ignored.
module game_cmd_fifo #(
   parameter int WIDTH = 2,
   parameter int DEPTH = 4
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             push,
   input  logic [WIDTH-1:0] din,
   input  logic             pop,
   output logic [WIDTH-1:0] dout,
   output logic             full,
   output logic             empty
);
   localparam int AW = $clog2(DEPTH);
   logic [WIDTH-1:0] mem_q [DEPTH];
   logic [AW-1:0] wr_q, rd_q;
   logic [AW:0] cnt_q;
   logic do_push, do_pop;
   assign full = cnt_q == (AW+1)'(DEPTH);
   assign empty = cnt_q == '0;
   assign do_push = push && !full;
   assign do_pop = pop && !empty;
   assign dout = mem_q[rd_q];
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         wr_q <= '0;
         rd_q <= '0;
         cnt_q <= '0;
      end else begin
         wr_q <= wr_q + AW'(do_push);
         rd_q <= rd_q + AW'(do_pop);
         cnt_q <= cnt_q + (AW+1)'(do_push) - (AW+1)'(do_pop);
      end
   end
   always_ff @(posedge clk)
      if (do_push) mem_q[wr_q] <= din;
endmodule

// File: rtl/game_move_sequencer.sv
// game_move_sequencer: per-player command FIFOs, tick-paced round-robin move issue with reversal filter.
// Ports: clk, rst_n (sync, active-low); tick step strobe; in_valid/in_dir/in_ready per-player
//        command inputs (player p on in_dir[2p+1:2p]); mv_valid/mv_player/mv_dir/mv_ready move
//        handshake to the core; drop per-player reversal-discard pulse; overrun sticky tick overrun.
// Optional: GAME_MOVE_CNT_EN adds move_cnt (16 bits per player, wrapping) and drop_cnt (saturating).
module game_move_sequencer
   import game_pkg::*;
#(
   parameter int N_PLAYERS = 2,
   parameter int DEPTH = 4,
   parameter int PW = (N_PLAYERS > 1) ? $clog2(N_PLAYERS) : 1
) (
   input  logic                     clk,
   input  logic                     rst_n,
   input  logic                     tick,
   input  logic [N_PLAYERS-1:0]     in_valid,
   input  logic [2*N_PLAYERS-1:0]   in_dir,
   output logic [N_PLAYERS-1:0]     in_ready,
   output logic                     mv_valid,
   output logic [PW-1:0]            mv_player,
   output logic [DIR_W_BITS-1:0]    mv_dir,
   input  logic                     mv_ready,
   output logic [N_PLAYERS-1:0]     drop,
`ifdef GAME_MOVE_CNT_EN
   output logic [16*N_PLAYERS-1:0]  move_cnt,
   output logic [15:0]              drop_cnt,
`endif
   output logic                     overrun
);
   state_e state_q, state_d;
   logic pending_q, pending_d, overrun_q, overrun_d;
   logic [PW-1:0] rr_q, rr_d, mv_player_q, mv_player_d;
   logic [DIR_W_BITS-1:0] mv_dir_q, mv_dir_d;
   logic [N_PLAYERS-1:0][DIR_W_BITS-1:0] last_dir_q, last_dir_d, head;
   logic [N_PLAYERS-1:0] last_ok_q, last_ok_d, full, empty, pop;
   logic [PW-1:0] win, idx;
   logic found, rev, arb, hs, round_end;
   function automatic logic [PW-1:0] wrap_inc(input logic [PW-1:0] p);
      return (int'(p) == N_PLAYERS - 1) ? '0 : p + 1'b1;
   endfunction
   for (genvar i = 0; i < N_PLAYERS; i++) begin : g_fifo
      game_cmd_fifo #(.WIDTH(DIR_W_BITS), .DEPTH(DEPTH)) u_fifo (
         .clk(clk),
         .rst_n(rst_n),
         .push(in_valid[i] && !full[i]),
         .din(in_dir[2*i +: 2]),
         .pop(pop[i]),
         .dout(head[i]),
         .full(full[i]),
         .empty(empty[i])
      );
   end
   assign in_ready = ~full;
   // First non-empty FIFO at or after rr_q, wrapping.
   always_comb begin
      found = 1'b0;
      win = rr_q;
      idx = rr_q;
      for (int k = 0; k < N_PLAYERS; k++) begin
         if (!found && !empty[idx]) begin
            found = 1'b1;
            win = idx;
         end
         idx = wrap_inc(idx);
      end
   end
   assign rev = last_ok_q[win] && head[win] == opposite(last_dir_q[win]);
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q <= ST_IDLE;
         pending_q <= 1'b0;
         overrun_q <= 1'b0;
         rr_q <= '0;
         mv_player_q <= '0;
         mv_dir_q <= '0;
         last_dir_q <= '0;
         last_ok_q <= '0;
      end else begin
         state_q <= state_d;
         pending_q <= pending_d;
         overrun_q <= overrun_d;
         rr_q <= rr_d;
         mv_player_q <= mv_player_d;
         mv_dir_q <= mv_dir_d;
         last_dir_q <= last_dir_d;
         last_ok_q <= last_ok_d;
      end
   end
   always_comb begin
      state_d = state_q;
      unique case (state_q)
         ST_IDLE:  state_d = pending_q ? ST_ARB : ST_IDLE;
         ST_ARB:   state_d = (found && !rev) ? ST_ISSUE : ST_IDLE;
         ST_ISSUE: state_d = mv_ready ? ST_IDLE : ST_ISSUE;
         default:  state_d = ST_IDLE;
      endcase
   end
   always_comb begin
      arb = state_q == ST_ARB;
      hs = state_q == ST_ISSUE && mv_ready;
      pop = '0;
      if (arb && found) pop[win] = 1'b1;
      drop = pop & {N_PLAYERS{rev}};
      mv_valid = state_q == ST_ISSUE;
      mv_player_d = (arb && found && !rev) ? win : mv_player_q;
      mv_dir_d = (arb && found && !rev) ? head[win] : mv_dir_q;
      // A round ends on an empty scan, a filtered reversal, or the core handshake.
      round_end = (arb && !(found && !rev)) || hs;
      pending_d = tick || (pending_q && !round_end);
      overrun_d = overrun_q || (tick && pending_q);
      rr_d = hs ? wrap_inc(mv_player_q) : (arb && found && rev) ? wrap_inc(win) : rr_q;
      last_dir_d = last_dir_q;
      last_ok_d = last_ok_q;
      if (hs) begin
         last_dir_d[mv_player_q] = mv_dir_q;
         last_ok_d[mv_player_q] = 1'b1;
      end
   end
   assign mv_player = mv_player_q;
   assign mv_dir = mv_dir_q;
   assign overrun = overrun_q;
`ifdef GAME_MOVE_CNT_EN
   logic [N_PLAYERS-1:0][15:0] move_cnt_q;
   logic [15:0] drop_cnt_q;
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         move_cnt_q <= '0;
         drop_cnt_q <= '0;
      end else begin
         if (hs) move_cnt_q[mv_player_q] <= move_cnt_q[mv_player_q] + 16'd1;
         if (|drop && drop_cnt_q != 16'hFFFF) drop_cnt_q <= drop_cnt_q + 16'd1;
      end
   end
   assign move_cnt = move_cnt_q;
   assign drop_cnt = drop_cnt_q;
`endif
endmodule

// File: tb/tb_game_move_sequencer.sv
// tb_game_move_sequencer: directed stimulus with a move/drop scoreboard for game_move_sequencer.
module tb_game_move_sequencer;
   localparam int NP = 2;
   localparam logic [1:0] N = 2'd0, E = 2'd1, S = 2'd2, W = 2'd3;
   logic clk = 0, rst_n = 0, tick = 0, mv_ready = 1;
   logic [NP-1:0] in_valid = '0, in_ready, drop;
   logic [2*NP-1:0] in_dir = '0;
   logic mv_valid, overrun;
   logic [0:0] mv_player;
   logic [1:0] mv_dir;
   int total = 0, passed = 0;
   typedef struct {int p; int d;} mv_t;
   mv_t exp_mv[$];
   int exp_drop[$];

   game_move_sequencer #(.N_PLAYERS(NP), .DEPTH(4)) dut (
      .clk(clk), .rst_n(rst_n), .tick(tick), .in_valid(in_valid), .in_dir(in_dir),
      .in_ready(in_ready), .mv_valid(mv_valid), .mv_player(mv_player), .mv_dir(mv_dir),
      .mv_ready(mv_ready), .drop(drop), .overrun(overrun)
   );

   always #5 clk = ~clk;

   task automatic chk(input string n, input logic [31:0] act, input logic [31:0] req);
      total++;
      if (act === req) passed++;
      else $display("FAIL %s: got %0h, required %0h", n, act, req);
   endtask

   task automatic fail(input string n, input string why);
      total++;
      $display("FAIL %s: %s", n, why);
   endtask

   // Scoreboard monitor: sampled mid-cycle, away from the active edge.
   always @(negedge clk) begin
      if (rst_n) begin
         if (mv_valid && mv_ready) begin
            if (exp_mv.size() == 0) fail("move_unexpected", $sformatf("got p%0d d%0d, required none", mv_player, mv_dir));
            else begin
               mv_t e;
               e = exp_mv.pop_front();
               chk("move_player", 32'(mv_player), e.p);
               chk("move_dir", 32'(mv_dir), e.d);
            end
         end
         if (|drop) begin
            if (exp_drop.size() == 0) fail("drop_unexpected", $sformatf("got %b, required 0", drop));
            else begin
               int p;
               p = exp_drop.pop_front();
               chk("drop_pulse", 32'(drop), 32'(1) << p);
            end
         end
      end
   end

   task automatic cyc(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic do_reset();
      rst_n = 0;
      tick = 0;
      in_valid = '0;
      cyc(2);
      rst_n = 1;
   endtask

   task automatic push(input int p, input logic [1:0] d);
      int n;
      n = 0;
      in_valid[p] = 1;
      in_dir[2*p +: 2] = d;
      while (!in_ready[p] && n < 50) begin
         cyc(1);
         n++;
      end
      if (n >= 50) fail("push_timeout", "in_ready stayed 0, required 1");
      cyc(1);
      in_valid[p] = 0;
   endtask

   task automatic tick_pulse();
      tick = 1;
      cyc(1);
      tick = 0;
   endtask

   task automatic tick_wait();
      tick_pulse();
      cyc(6);
   endtask

   function automatic mv_t mv(input int p, input int d);
      mv_t m;
      m.p = p;
      m.d = d;
      return m;
   endfunction

   initial begin
      #500000;
      $display("FAIL watchdog: run still active at time limit, required finish");
      $fatal(1);
   end

   initial begin
      // Reset state
      do_reset();
      @(negedge clk);
      chk("rst_in_ready", 32'(in_ready), 2'b11);
      chk("rst_mv_valid", 32'(mv_valid), 0);
      chk("rst_mv_player", 32'(mv_player), 0);
      chk("rst_mv_dir", 32'(mv_dir), 0);
      chk("rst_drop", 32'(drop), 0);
      chk("rst_overrun", 32'(overrun), 0);
      cyc(1);
      // E, S, E issued in order; first tick also measures 3-cycle latency
      push(0, E); push(0, S); push(0, E);
      exp_mv.push_back(mv(0, E)); exp_mv.push_back(mv(0, S)); exp_mv.push_back(mv(0, E));
      tick_pulse();
      @(negedge clk); chk("lat_c1", 32'(mv_valid), 0);
      @(negedge clk); chk("lat_c2", 32'(mv_valid), 0);
      @(negedge clk); chk("lat_c3", 32'(mv_valid), 1);
      cyc(4);
      tick_wait();
      tick_wait();
      // Last P0 move was E: E passes, W is a reversal and is dropped
      push(0, E); push(0, W);
      exp_mv.push_back(mv(0, E));
      exp_drop.push_back(0);
      tick_wait();
      tick_wait();
      chk("fifo0_drained", 32'(in_ready), 2'b11);
      // Round-robin alternation
      do_reset();
      fork push(0, N); push(1, S); join
      fork push(0, N); push(1, S); join
      exp_mv.push_back(mv(0, N)); exp_mv.push_back(mv(1, S));
      exp_mv.push_back(mv(0, N)); exp_mv.push_back(mv(1, S));
      repeat (4) tick_wait();
      // FIFO full after DEPTH pushes; 5th push held until a pop frees space
      do_reset();
      push(0, E); push(0, E); push(0, E);
      chk("ready_after3", 32'(in_ready[0]), 1);
      push(0, E);
      chk("ready_after4", 32'(in_ready[0]), 0);
      chk("ready_p1", 32'(in_ready[1]), 1);
      repeat (4) exp_mv.push_back(mv(0, E));
      exp_mv.push_back(mv(0, N));
      fork push(0, N); tick_pulse(); join
      cyc(1);
      chk("ready_refull", 32'(in_ready[0]), 0);
      cyc(6);
      repeat (4) tick_wait();
      chk("ready_empty", 32'(in_ready[0]), 1);
      // Core back-pressure: outputs hold, extra ticks raise overrun
      do_reset();
      mv_ready = 0;
      push(0, W);
      exp_mv.push_back(mv(0, W));
      tick_pulse();
      cyc(2);
      @(negedge clk);
      chk("bp_valid", 32'(mv_valid), 1);
      chk("bp_overrun0", 32'(overrun), 0);
      for (int c = 0; c < 10; c++) begin
         tick = (c == 2 || c == 5);
         cyc(1);
         tick = 0;
         @(negedge clk);
         chk("hold_valid", 32'(mv_valid), 1);
         chk("hold_player", 32'(mv_player), 0);
         chk("hold_dir", 32'(mv_dir), W);
      end
      chk("overrun_set", 32'(overrun), 1);
      cyc(1);
      mv_ready = 1;
      cyc(8);
      chk("bp_done", 32'(mv_valid), 0);
      chk("overrun_sticky", 32'(overrun), 1);
      // Reset during ISSUE clears in-flight move, FIFOs and reversal history
      do_reset();
      push(0, E);
      exp_mv.push_back(mv(0, E));
      tick_wait();
      mv_ready = 0;
      push(0, E); push(0, N);
      tick_pulse();
      cyc(2);
      @(negedge clk);
      chk("pre_rst_valid", 32'(mv_valid), 1);
      cyc(1);
      rst_n = 0;
      cyc(1);
      rst_n = 1;
      @(negedge clk);
      chk("rst_mid_valid", 32'(mv_valid), 0);
      chk("rst_mid_ready", 32'(in_ready), 2'b11);
      chk("rst_mid_dir", 32'(mv_dir), 0);
      cyc(1);
      mv_ready = 1;
      push(0, W);
      exp_mv.push_back(mv(0, W));
      tick_wait();
      tick_wait();
      chk("mv_queue_empty", exp_mv.size(), 0);
      chk("drop_queue_empty", exp_drop.size(), 0);
      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end
endmodule

// File: doc/game_move_sequencer.md
Name: game_move_sequencer

Overview:
- Parametrised multi-player move front-end for the Game core.
- Buffers per-player direction commands (N/E/S/W) in FIFOs.
- On each game step tick, selects one player round-robin, filters illegal 180° reversals, and issues one move to the core over a valid/ready handshake.
- Replaces single-player, one-command-at-a-time driving of the core.

Parameters:
- N_PLAYERS, 2, number of independent command channels (1..8).
- DEPTH, 4, per-player FIFO depth in entries; power of two, at least 2.
- PW, $clog2(N_PLAYERS) with a minimum of 1, player index width.

Ports:
- clk  in  1  system clock, rising edge.
- rst_n  in  1  synchronous, active-low reset.
- tick  in  1  game step strobe, one cycle wide.
- in_valid  in  N_PLAYERS  per-player command valid.
- in_dir  in  2*N_PLAYERS  per-player direction; player p uses bits [2p+1:2p].
- in_ready  out  N_PLAYERS  per-player FIFO not full.
- mv_valid  out  1  move valid to core.
- mv_player  out  PW  player index of the issued move.
- mv_dir  out  2  direction of the issued move.
- mv_ready  in  1  core accepts the move.
- drop  out  N_PLAYERS  one-cycle pulse when a reversal is discarded.
- overrun  out  1  sticky: a tick arrived while one was already pending.

Behaviour:
- Direction encoding: N=0, E=1, S=2, W=3. opposite(d) = d ^ 2'b10.
- Push: entry written when in_valid[p] && in_ready[p].
  - in_ready[p] = !full[p], so it depends on FIFO state only.
  - Push and pop on the same player in one cycle are both performed.
- Tick latch:
  - tick sets pending; pending is cleared when an arbitration round ends.
  - tick while pending is already set sets overrun. overrun clears only on reset.
- FSM states: IDLE, ARB, ISSUE.
- IDLE -> ARB: when pending is set.
- ARB (one cycle):
  - Scan players starting at rr_ptr for the first non-empty FIFO.
  - No non-empty FIFO: clear pending, return to IDLE, rr_ptr unchanged.
  - Winner w found: pop its head and test it.
    - If last_ok[w] && head == opposite(last_dir[w]): pulse drop[w] for one cycle, discard the entry, clear pending, set rr_ptr = w+1 (wrapping modulo N_PLAYERS), return to IDLE.
    - Otherwise: load mv_player = w and mv_dir = head, then go to ISSUE.
- ISSUE:
  - mv_valid = 1; mv_player and mv_dir are held stable until the handshake.
  - On mv_ready: last_dir[w] = mv_dir, last_ok[w] = 1, rr_ptr = w+1 (wrapping), clear pending, go to IDLE.
- Latency: tick to mv_valid is 3 cycles (tick->pending, IDLE->ARB, ARB->ISSUE), assuming an idle FSM.
- Throughput: at most one move per tick; each tick serves exactly one player or none.
- A tick arriving during ARB or ISSUE is latched as the next pending tick, not lost.
- Reset values:
  - in_ready all 1; mv_valid 0; mv_player 0; mv_dir 0; drop 0; overrun 0.
  - FIFOs empty; last_ok all 0; rr_ptr 0; state IDLE.
- Reset asserted mid-operation abandons any in-flight move; mv_valid is 0 the cycle after reset is sampled.
- The first move of each player after reset is never filtered.

Optional Feature:
- Macro: GAME_MOVE_CNT_EN.
- Defined:
  - Adds output move_cnt (16*N_PLAYERS bits): per-player 16-bit count of accepted moves, incremented on the mv_valid && mv_ready handshake. Counters wrap at 0xFFFF -> 0 and reset to 0.
  - Adds output drop_cnt (16 bits): total reversal drops across all players, saturating at 0xFFFF.
- Not defined: neither port exists and no counter logic is generated.

Decomposition:
- Shared package game_pkg:
  - typedef enum logic [1:0] dir_e {DIR_N, DIR_E, DIR_S, DIR_W}.
  - function opposite().
  - localparam DIR_W_BITS = 2.
- Sub-module game_cmd_fifo (WIDTH, DEPTH): synchronous FIFO with push, pop, dout, full, empty.
  - Head is visible combinationally at dout.
  - Instantiated N_PLAYERS times.

Test Plan:
- N_PLAYERS=1, push E, S, E, then 3 ticks, mv_ready held 1 -> moves E, S, E issued in order with mv_player 0; drop stays 0.
- Push E then W, 2 ticks -> E issued; W dropped with drop[0] pulsing once; no second mv_valid.
- N_PLAYERS=2: P0 pushes N, N; P1 pushes S, S; 4 ticks -> issue order P0 N, P1 S, P0 N, P1 S (round-robin alternates).
- DEPTH=4: push 5 commands back-to-back without ticks -> in_ready[0] drops after the 4th push; the 5th is held by its source until a pop.
- mv_ready held 0 for 10 cycles, 2 extra ticks sent -> mv_valid, mv_player, mv_dir stay stable; overrun = 1 after the second extra tick; the move completes once mv_ready rises.
- rst_n low for 1 cycle while in ISSUE -> next cycle mv_valid=0, FIFOs empty, in_ready all 1; a subsequent W after reset is issued, not filtered.
